// File: rtl/align_pkg.sv
// Shared types and constants for the receive-side word alignment controller.
// The K28.5 comma in both running-disparity forms is the default alignment code.
package align_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_e;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

endpackage

// File: rtl/comma_match.sv
// Combinational comma detector: flags the sliding window when it holds either
// disparity form of the alignment code.
module comma_match
    import align_pkg::*;
#(
    parameter int                WIDTH   = 10,
    parameter logic [WIDTH-1:0]  COMMA_P = K28_5_RDN,
    parameter logic [WIDTH-1:0]  COMMA_N = K28_5_RDP
) (
    input  logic [WIDTH-1:0] window_i,
    output logic             comma_o
);

    assign comma_o = (window_i == COMMA_P) || (window_i == COMMA_N);

endmodule

// File: rtl/word_align_ctrl.sv
// Symbol-alignment controller. Hunts for commas in the bit-sliding window,
// confirms a stable boundary with LOCK_CNT aligned commas, then emits one
// registered word per boundary while locked. Lock is dropped after UNLOCK_CNT
// off-boundary commas (the last one immediately seeds a new CONFIRM) or after
// TIMEOUT_WORDS boundaries without an aligned comma.
// Optional feature macro: ALIGN_STATS_EN adds realign_cnt / lock_loss_cnt.
module word_align_ctrl
    import align_pkg::*;
#(
    parameter int                WIDTH         = 10,
    parameter logic [WIDTH-1:0]  COMMA_P       = K28_5_RDN,
    parameter logic [WIDTH-1:0]  COMMA_N       = K28_5_RDP,
    parameter int                LOCK_CNT      = 3,
    parameter int                UNLOCK_CNT    = 4,
    parameter int                TIMEOUT_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] Data_Collected,
    output logic [WIDTH-1:0] word_out,
    output logic             RxValid,
    output logic             Comma_Pulse,
    output logic             sym_lock,
    output logic             realign
`ifdef ALIGN_STATS_EN
    ,
    output logic [15:0]      realign_cnt,
    output logic [7:0]       lock_loss_cnt
`endif
);

    localparam int PW = $clog2(WIDTH);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_WORDS + 1);

    align_state_e     state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [HW-1:0]    hits_q, hits_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             rxv_q, rxv_d;
    logic             cp_q, cp_d;
    logic             lock_q, lock_d;
    logic             ra_q, ra_d;

    logic             comma;
    logic             boundary;
    logic             start_align;
    logic             go_hunt;
    logic [HW-1:0]    hits_inc;
    logic [MW-1:0]    miss_inc;
    logic [TW-1:0]    tmo_inc;
    logic             hits_full;
    logic             miss_full;
    logic             tmo_full;

    comma_match #(
        .WIDTH   (WIDTH),
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_comma_match (
        .window_i (Data_Collected),
        .comma_o  (comma)
    );

    assign boundary = (phase_q == '0);

    // Saturating increments and "this event reaches the threshold" flags.
    assign hits_inc  = (int'(hits_q) >= LOCK_CNT)      ? hits_q : hits_q + 1'b1;
    assign miss_inc  = (int'(miss_q) >= UNLOCK_CNT)    ? miss_q : miss_q + 1'b1;
    assign tmo_inc   = (int'(tmo_q)  >= TIMEOUT_WORDS) ? tmo_q  : tmo_q + 1'b1;
    assign hits_full = (int'(hits_q) + 1 >= LOCK_CNT);
    assign miss_full = (int'(miss_q) + 1 >= UNLOCK_CNT);
    assign tmo_full  = (int'(tmo_q)  + 1 >= TIMEOUT_WORDS);

    // Next-state, counter and output decode for the alignment FSM.
    always_comb begin
        state_d     = state_q;
        phase_d     = (phase_q == PW'(WIDTH - 1)) ? '0 : phase_q + 1'b1;
        hits_d      = hits_q;
        miss_d      = miss_q;
        tmo_d       = tmo_q;
        word_d      = word_q;
        rxv_d       = 1'b0;
        cp_d        = 1'b0;
        ra_d        = 1'b0;
        start_align = 1'b0;
        go_hunt     = 1'b0;

        if (!en) begin
            state_d = HUNT;
            phase_d = '0;
            hits_d  = '0;
            miss_d  = '0;
            tmo_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    start_align = comma;
                end
                CONFIRM: begin
                    if (comma && boundary) begin
                        hits_d = hits_inc;
                        tmo_d  = '0;
                        // Reaching the lock count wins over any starvation.
                        if (hits_full) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                            word_d  = Data_Collected;
                            rxv_d   = 1'b1;
                            cp_d    = 1'b1;
                        end
                    end else if (comma) begin
                        start_align = 1'b1;
                    end else if (boundary) begin
                        tmo_d = tmo_inc;
                        if (tmo_full) go_hunt = 1'b1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        // Every boundary word goes out, including the one that times out.
                        word_d = Data_Collected;
                        rxv_d  = 1'b1;
                        if (comma) begin
                            cp_d   = 1'b1;
                            miss_d = '0;
                            tmo_d  = '0;
                        end else begin
                            tmo_d = tmo_inc;
                            if (tmo_full) go_hunt = 1'b1;
                        end
                    end else if (comma) begin
                        miss_d = miss_inc;
                        // The comma that breaks lock becomes the first hit of a new boundary.
                        if (miss_full) start_align = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (start_align) begin
                state_d = CONFIRM;
                phase_d = PW'(1);
                hits_d  = HW'(1);
                miss_d  = '0;
                tmo_d   = '0;
                ra_d    = 1'b1;
                if (LOCK_CNT <= 1) begin
                    state_d = LOCKED;
                    word_d  = Data_Collected;
                    rxv_d   = 1'b1;
                    cp_d    = 1'b1;
                end
            end

            if (go_hunt) begin
                state_d = HUNT;
                hits_d  = '0;
                miss_d  = '0;
                tmo_d   = '0;
            end
        end

        lock_d = (state_d == LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            phase_q <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            tmo_q   <= '0;
            word_q  <= '0;
            rxv_q   <= 1'b0;
            cp_q    <= 1'b0;
            lock_q  <= 1'b0;
            ra_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            tmo_q   <= tmo_d;
            word_q  <= word_d;
            rxv_q   <= rxv_d;
            cp_q    <= cp_d;
            lock_q  <= lock_d;
            ra_q    <= ra_d;
        end
    end

    assign word_out    = word_q;
    assign RxValid     = rxv_q;
    assign Comma_Pulse = cp_q;
    assign sym_lock    = lock_q;
    assign realign     = ra_q;

`ifdef ALIGN_STATS_EN
    logic [15:0] realign_cnt_q;
    logic [7:0]  lock_loss_cnt_q;

    // Saturating statistics; only rst clears them, en has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            realign_cnt_q   <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            if (ra_d && (realign_cnt_q != '1))
                realign_cnt_q <= realign_cnt_q + 1'b1;
            if ((state_q == LOCKED) && (state_d != LOCKED) && (lock_loss_cnt_q != '1))
                lock_loss_cnt_q <= lock_loss_cnt_q + 1'b1;
        end
    end

    assign realign_cnt   = realign_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_word_align_ctrl.sv
// Bench for word_align_ctrl: randomized symbol stream with directed comma
// placement, a time-based reference model, and a queue-driven monitor.
module tb_word_align_ctrl;

    localparam int         W      = 10;
    localparam logic [9:0] CP     = 10'h0FA;
    localparam logic [9:0] CN     = 10'h305;
    localparam int         LOCK_N = 3;
    localparam int         UNLK_N = 4;
    localparam int         TMO_N  = 8;

    localparam int M_HUNT = 0;
    localparam int M_CONF = 1;
    localparam int M_LOCK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [9:0] dc;
    logic [9:0] word_out;
    logic       rxv, cp, lk, ra;
`ifdef ALIGN_STATS_EN
    logic [15:0] rcnt;
    logic [7:0]  lcnt;
`endif

    word_align_ctrl #(
        .TIMEOUT_WORDS (TMO_N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .Data_Collected (dc),
        .word_out       (word_out),
        .RxValid        (rxv),
        .Comma_Pulse    (cp),
        .sym_lock       (lk),
        .realign        (ra)
`ifdef ALIGN_STATS_EN
        ,
        .realign_cnt    (rcnt),
        .lock_loss_cnt  (lcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rxv;
        logic        cp;
        logic        lk;
        logic        ra;
        logic [9:0]  w;
        logic [15:0] rc;
        logic [7:0]  lc;
    } stat_t;

    stat_t       stat_q[$];
    logic [10:0] exp_q[$];   // {comma_pulse, word} per expected RxValid

    int n_tests = 0;
    int n_fail  = 0;
    int mon_cyc = 0;

    // Reference model state: alignment is tracked as the clock index of the
    // comma that set it; a boundary is any clock a multiple of W after it.
    int         mode   = M_HUNT;
    longint     cyc    = 0;
    longint     anchor = 0;
    int         hits   = 0;
    int         miss   = 0;
    int         starve = 0;
    logic [9:0] m_word = '0;
    int         m_rc   = 0;
    int         m_lc   = 0;

    task automatic model(input logic r, input logic e, input logic [9:0] d);
        stat_t s;
        int    prev;
        logic  comma, on_b, do_start;
        s        = '0;
        prev     = mode;
        comma    = (d == CP) || (d == CN);
        on_b     = ((cyc - anchor) % W) == 0;
        do_start = 1'b0;
        if (r) begin
            mode = M_HUNT; hits = 0; miss = 0; starve = 0;
            m_word = '0; m_rc = 0; m_lc = 0; prev = M_HUNT;
        end else if (!e) begin
            mode = M_HUNT; hits = 0; miss = 0; starve = 0; m_word = '0;
        end else begin
            case (mode)
                M_HUNT: do_start = comma;
                M_CONF: begin
                    if (comma && on_b) begin
                        hits++; starve = 0;
                        if (hits >= LOCK_N) begin
                            mode = M_LOCK; m_word = d; s.rxv = 1'b1; s.cp = 1'b1;
                            exp_q.push_back({1'b1, d});
                        end
                    end else if (comma) begin
                        do_start = 1'b1;
                    end else if (on_b) begin
                        starve++;
                        if (starve >= TMO_N) mode = M_HUNT;
                    end
                end
                default: begin
                    if (on_b) begin
                        m_word = d; s.rxv = 1'b1; s.cp = comma;
                        exp_q.push_back({comma, d});
                        if (comma) begin
                            miss = 0; starve = 0;
                        end else begin
                            starve++;
                            if (starve >= TMO_N) mode = M_HUNT;
                        end
                    end else if (comma) begin
                        miss++;
                        if (miss >= UNLK_N) do_start = 1'b1;
                    end
                end
            endcase
            if (do_start) begin
                mode = M_CONF; anchor = cyc; hits = 1; miss = 0; starve = 0;
                s.ra = 1'b1;
                if (m_rc < 65535) m_rc++;
            end
            if (mode == M_HUNT) begin
                hits = 0; miss = 0; starve = 0;
            end
        end
        if (prev == M_LOCK && mode != M_LOCK && m_lc < 255) m_lc++;
        s.lk = (mode == M_LOCK);
        s.w  = m_word;
`ifdef ALIGN_STATS_EN
        s.rc = 16'(m_rc);
        s.lc = 8'(m_lc);
`endif
        stat_q.push_back(s);
        cyc++;
    endtask

    function automatic logic [9:0] rand_nc();
        logic [9:0] v;
        do v = 10'($urandom_range(0, 1023)); while (v == CP || v == CN);
        return v;
    endfunction

    // Drive one clock of input and record the expected response to it.
    task automatic step(input logic r, input logic e, input logic [9:0] d);
        rst = r; en = e; dc = d;
        model(r, e, d);
        @(posedge clk);
        #1;
    endtask

    // Ten clocks with an optional comma at offset off (off outside 0..9 = none).
    task automatic send_word(input int off, input logic [9:0] code);
        for (int i = 0; i < W; i++)
            step(1'b0, 1'b1, (i == off) ? code : rand_nc());
    endtask

    // Monitor: per-clock status check, plus word check whenever RxValid is seen.
    always @(negedge clk) begin
        stat_t       a;
        stat_t       x;
        logic [10:0] ew;
        mon_cyc++;
        if (stat_q.size() > 0) begin
            x = stat_q.pop_front();
            a = '0;
            a.rxv = rxv; a.cp = cp; a.lk = lk; a.ra = ra; a.w = word_out;
`ifdef ALIGN_STATS_EN
            a.rc = rcnt; a.lc = lcnt;
`endif
            n_tests++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL status clk=%0d: got rxv=%b cp=%b lock=%b realign=%b word=%h rc=%0d lc=%0d, want rxv=%b cp=%b lock=%b realign=%b word=%h rc=%0d lc=%0d",
                         mon_cyc, a.rxv, a.cp, a.lk, a.ra, a.w, a.rc, a.lc,
                         x.rxv, x.cp, x.lk, x.ra, x.w, x.rc, x.lc);
            end
        end
        if (rxv === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word clk=%0d: got unexpected RxValid word=%h, want none", mon_cyc, word_out);
            end else begin
                ew = exp_q.pop_front();
                if ({cp, word_out} !== ew) begin
                    n_fail++;
                    $display("FAIL word clk=%0d: got cp=%b word=%h, want cp=%b word=%h",
                             mon_cyc, cp, word_out, ew[10], ew[9:0]);
                end
            end
        end
    end

    initial begin
        int off;
        // Reset, then a comma-free stream: nothing may come out.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_nc());
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, rand_nc());

        // Acquire lock with both disparity forms at word spacing.
        send_word(0, CP);
        send_word(0, CN);
        send_word(0, CP);
        send_word(-1, CP);
        send_word(-1, CP);

        // A single stray comma, then an aligned one: lock holds.
        send_word(4, CP);
        send_word(0, CN);
        send_word(-1, CP);

        // Four stray commas in a row: lock drops and the last one realigns.
        for (int i = 0; i < UNLK_N; i++) send_word(4, CP);
        send_word(4, CN);
        send_word(4, CP);
        send_word(-1, CP);

        // Comma starvation: timeout back to HUNT.
        for (int i = 0; i < TMO_N + 2; i++) send_word(-1, CP);

        // Relock, then pull en low for one clock mid-word.
        for (int i = 0; i < LOCK_N; i++) send_word(0, CP);
        send_word(-1, CP);
        for (int i = 0; i < W; i++) step(1'b0, (i != 5), rand_nc());
        send_word(-1, CP);
        for (int i = 0; i < LOCK_N; i++) send_word(0, CN);
        send_word(-1, CP);

        // Randomized traffic: aligned, stray and missing commas plus rare en drops.
        for (int k = 0; k < 150; k++) begin
            off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 199) == 0)
                    step(1'b0, 1'b0, rand_nc());
                else
                    step(1'b0, 1'b1, (i == off) ? (($urandom_range(0, 1) == 1) ? CP : CN) : rand_nc());
            end
        end

        // Let the monitor drain everything that was issued.
        step(1'b0, 1'b1, rand_nc());
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words and %0d status entries left, want 0 and 0",
                     exp_q.size(), stat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
